gather_credit_returner: RTL and testbench

//  Receive end of the gather FC credit loop. Sits at the gather destination port.

---
 rtl/gather_credit_returner.sv | 144 ++++++++++++++
 tb/tb_gather_credit_returner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gather_credit_returner.sv
// Receive end of the gather flow-control credit loop: buffers incoming flits,
// returns one credit per flit popped, and tracks packet framing and length.
module gather_credit_returner #(
  parameter int x_pos = 0,
  parameter int y_pos = 0,
  parameter int FCpl  = 16,
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_flit,
  input  logic [1:0]               in_type,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_flit,
  output logic [1:0]               out_type,
  output logic                     credit_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     pkt_done,
  output logic                     len_err,
  output logic                     frame_err,
  output logic                     ovf_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [1:0] HEAD     = 2'd0;
  localparam logic [1:0] BODY     = 2'd1;
  localparam logic [1:0] TAIL     = 2'd2;
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [16:0] PKT_LEN = 17'(FCpl);

  typedef enum logic {IDLE, PKT} state_t;

  if (FCpl < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || x_pos < 0 || y_pos < 0) begin : g_param_check
    $error("gather_credit_returner: illegal parameter set");
  end

  logic [DW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          push;
  logic          pop;
  logic          ovf;

  state_t        state;
  state_t        state_next;
  logic [15:0]   cnt;
  logic [15:0]   cnt_next;
  logic [15:0]   cnt_sat;
  logic          frame_next;
  logic          len_next;
  logic          done_next;

  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push      = in_valid & ((occ != FULL) | pop);
  assign ovf       = in_valid & ~push;
  assign {out_type, out_flit} = mem[rd_ptr];
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_type, in_flit};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      credit_out <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      credit_out <= pop;
      ovf_err    <= ovf_err | ovf;
    end
  end

  assign cnt_sat = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Framing follows every arriving flit, including ones dropped on overflow.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    frame_next = frame_err;
    len_next   = len_err;
    done_next  = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (in_type == HEAD) begin
            state_next = PKT;
            cnt_next   = 16'd1;
          end else begin
            frame_next = 1'b1;
          end
        end
        default: begin
          case (in_type)
            HEAD: begin
              frame_next = 1'b1;
              cnt_next   = 16'd1;
            end
            BODY: cnt_next = cnt_sat;
            TAIL: begin
              done_next  = 1'b1;
              state_next = IDLE;
              cnt_next   = 16'd0;
              if (({1'b0, cnt} + 17'd1) != PKT_LEN) len_next = 1'b1;
            end
            default: frame_next = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_err <= 1'b0;
      len_err   <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      frame_err <= frame_next;
      len_err   <= len_next;
      pkt_done  <= done_next;
    end
  end

endmodule

// File: tb/tb_gather_credit_returner.sv
// Bench for gather_credit_returner: scoreboarded data path, occupancy and
// credit model, plus a framing vector table and multi-cycle corner sequences.
module tb_gather_credit_returner;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int FCPL  = 16;
  localparam logic [1:0] HEAD = 2'd0;
  localparam logic [1:0] BODY = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_flit = '0;
  logic [1:0]    in_type = HEAD;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_flit;
  logic [1:0]    out_type;
  logic          credit_out;
  logic [5:0]    occupancy;
  logic          pkt_done;
  logic          len_err;
  logic          frame_err;
  logic          ovf_err;

  gather_credit_returner #(.x_pos(0), .y_pos(0), .FCpl(FCPL), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_flit(in_flit), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit), .out_type(out_type),
    .credit_out(credit_out), .occupancy(occupancy), .pkt_done(pkt_done),
    .len_err(len_err), .frame_err(frame_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         v;
    logic [1:0] t;
    bit         pd;
    bit         fe;
    bit         le;
  } vec_t;

  vec_t        tbl[$];
  logic [33:0] sb[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          m_occ = 0;
  int          cred_cnt = 0;
  int          pd_cnt = 0;
  logic [31:0] seq = 32'h1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input logic v, input logic [1:0] t, input logic rdy);
    logic        pop;
    logic        push;
    logic [33:0] exp;
    in_valid  = v;
    in_type   = t;
    in_flit   = seq;
    out_ready = rdy;
    #3;
    pop  = (m_occ != 0) && rdy;
    push = v && ((m_occ < DEPTH) || pop);
    check("out_valid", out_valid, m_occ != 0);
    if (pop) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        exp = sb.pop_front();
        check("out_data", {out_type, out_flit}, exp);
      end
    end
    if (push) sb.push_back({t, seq});
    seq   = seq + 1;
    m_occ = m_occ + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    check("occupancy", occupancy, m_occ);
    check("credit_out", credit_out, pop);
    if (credit_out) cred_cnt++;
    if (pkt_done) pd_cnt++;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_occupancy", occupancy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_credit", credit_out, 0);
    check("rst_errors", {pkt_done, len_err, frame_err, ovf_err}, 0);
    sb.delete();
    m_occ = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_credit_hold", credit_out, 0);
    end
    rstn     = 1'b1;
    cred_cnt = 0;
    pd_cnt   = 0;
  endtask

  task automatic send_pkt(input int len, input logic rdy);
    cycle(1'b1, HEAD, rdy);
    for (int i = 0; i < len - 2; i++) cycle(1'b1, BODY, rdy);
    cycle(1'b1, TAIL, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && m_occ != 0; i++) cycle(1'b0, BODY, 1'b1);
    cycle(1'b0, BODY, 1'b1);
  endtask

  task automatic add(input bit rst, input bit v, input logic [1:0] t, input bit pd, input bit fe, input bit le);
    vec_t e;
    e.rst = rst; e.v = v; e.t = t; e.pd = pd; e.fe = fe; e.le = le;
    tbl.push_back(e);
  endtask

  initial begin
    // Framing table: illegal types in IDLE, then HEAD inside a packet restarting the count.
    add(1, 0, HEAD, 0, 0, 0);
    add(0, 1, BODY, 0, 1, 0);
    add(0, 1, TAIL, 0, 1, 0);
    add(1, 0, HEAD, 0, 0, 0);
    add(0, 1, HEAD, 0, 0, 0);
    add(0, 1, BODY, 0, 0, 0);
    add(0, 1, HEAD, 0, 1, 0);
    for (int i = 0; i < FCPL - 2; i++) add(0, 1, BODY, 0, 1, 0);
    add(0, 1, TAIL, 1, 1, 0);
    add(0, 0, BODY, 0, 1, 0);

    #1;
    do_reset();

    // 1: one legal packet streamed straight through
    send_pkt(FCPL, 1'b1);
    drain();
    check("t1_credits", cred_cnt, FCPL);
    check("t1_pkt_done", pd_cnt, 1);
    check("t1_errors", {len_err, frame_err, ovf_err}, 0);

    // 2: fill to full with consumer stalled, then overflow
    do_reset();
    send_pkt(FCPL, 1'b0);
    send_pkt(FCPL, 1'b0);
    check("t2_full", occupancy, DEPTH);
    check("t2_ovf_before", ovf_err, 0);
    cycle(1'b1, HEAD, 1'b0);
    check("t2_ovf", ovf_err, 1);
    check("t2_no_credit", cred_cnt, 0);
    drain();

    // 3: simultaneous push and pop at full
    do_reset();
    send_pkt(FCPL, 1'b0);
    send_pkt(FCPL, 1'b0);
    cycle(1'b1, HEAD, 1'b1);
    check("t3_ovf", ovf_err, 0);
    check("t3_credit", cred_cnt, 1);
    drain();
    check("t3_total_credits", cred_cnt, DEPTH + 1);

    // 4: short packet raises len_err at the TAIL but is still delivered
    do_reset();
    cycle(1'b1, HEAD, 1'b1);
    for (int i = 0; i < FCPL - 3; i++) cycle(1'b1, BODY, 1'b1);
    check("t4_len_before", len_err, 0);
    cycle(1'b1, TAIL, 1'b1);
    check("t4_len_err", len_err, 1);
    check("t4_pkt_done", pkt_done, 1);
    drain();
    check("t4_credits", cred_cnt, FCPL - 1);
    check("t4_frame", frame_err, 0);

    // 5: framing vector table
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        cycle(tbl[i].v, tbl[i].t, 1'b1);
        check($sformatf("t5_pkt_done[%0d]", i), pkt_done, tbl[i].pd);
        check($sformatf("t5_frame_err[%0d]", i), frame_err, tbl[i].fe);
        check($sformatf("t5_len_err[%0d]", i), len_err, tbl[i].le);
      end
    end
    drain();

    // 6: reset with flits buffered discards them without credits
    do_reset();
    cycle(1'b1, HEAD, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, BODY, 1'b0);
    check("t6_buffered", occupancy, 5);
    do_reset();
    send_pkt(FCPL, 1'b1);
    drain();
    check("t6_credits", cred_cnt, FCPL);
    check("t6_pkt_done", pd_cnt, 1);
    check("t6_errors", {len_err, frame_err, ovf_err}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
